// File: rtl/a51_keystream_core.sv
// a51_keystream_core: A5/1 LFSR keystream generator stepped by the sequencer's one-hot stage strobes
module a51_keystream_core #(
  parameter int KEY_BITS   = 64,
  parameter int FRAME_BITS = 22,
  parameter int MIX_CYCLES = 100,
  parameter int OUT_BITS   = 228
) (
  input  logic clk,
  input  logic clr,
  input  logic enable,
  input  logic stage_one,
  input  logic stage_two,
  input  logic stage_three,
  input  logic output_stage,
  input  logic done,
  input  logic key_bit,
  input  logic frame_bit,
  input  logic data_bit,
  output logic ks_bit,
  output logic cipher_bit,
  output logic ks_valid,
  output logic seq_err
);
  localparam int CW = $clog2(OUT_BITS + 1);
  localparam logic [CW-1:0] KEY_N   = CW'(KEY_BITS);
  localparam logic [CW-1:0] FRAME_N = CW'(FRAME_BITS);
  localparam logic [CW-1:0] MIX_N   = CW'(MIX_CYCLES);
  localparam logic [CW-1:0] OUT_N   = CW'(OUT_BITS);
  typedef enum logic [2:0] {IDLE, KEY, FRAME, MIX, OUT, HOLD} state_t;
  state_t state, phase;
  logic [18:0] r1, b1, r1_n;
  logic [21:0] r2, b2, r2_n;
  logic [22:0] r3, b3, r3_n;
  logic [CW-1:0] cnt, cnt_n, exp_len;
  logic entry, load, emit, maj, fb_in, s1, s2, s3, ks_n, err;
  always_comb begin
    phase = stage_one ? KEY : stage_two ? FRAME : stage_three ? MIX : output_stage ? OUT : done ? HOLD : IDLE;
    entry = phase != state;
    load = phase == KEY || phase == FRAME;
    emit = phase == OUT && (entry || cnt < OUT_N);
    fb_in = load && (phase == KEY ? key_bit : frame_bit);
    // a fresh KEY phase starts a new session from all-zero registers
    b1 = phase == KEY && entry ? '0 : r1;
    b2 = phase == KEY && entry ? '0 : r2;
    b3 = phase == KEY && entry ? '0 : r3;
    maj = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
    s1 = load || ((phase == MIX || emit) && r1[8] == maj);
    s2 = load || ((phase == MIX || emit) && r2[10] == maj);
    s3 = load || ((phase == MIX || emit) && r3[10] == maj);
    r1_n = s1 ? {b1[17:0], ^(b1 & 19'h72000) ^ fb_in} : b1;
    r2_n = s2 ? {b2[20:0], ^(b2 & 22'h300000) ^ fb_in} : b2;
    r3_n = s3 ? {b3[21:0], ^(b3 & 23'h700080) ^ fb_in} : b3;
    ks_n = r1_n[18] ^ r2_n[21] ^ r3_n[22];
    cnt_n = entry ? CW'(1) : &cnt ? cnt : cnt + CW'(1);
    exp_len = state == KEY ? KEY_N : state == FRAME ? FRAME_N : state == MIX ? MIX_N : OUT_N;
    err = entry && state inside {KEY, FRAME, MIX, OUT} && cnt != exp_len;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
      cnt <= '0;
      ks_bit <= 1'b0;
      cipher_bit <= 1'b0;
      ks_valid <= 1'b0;
      seq_err <= 1'b0;
    end else if (!enable) begin
      ks_valid <= 1'b0;
    end else begin
      state <= phase;
      r1 <= r1_n;
      r2 <= r2_n;
      r3 <= r3_n;
      cnt <= cnt_n;
      seq_err <= seq_err | err;
      ks_valid <= emit;
      if (emit) begin
        ks_bit <= ks_n;
        cipher_bit <= ks_n ^ data_bit;
      end
    end
  end
endmodule

// File: tb/tb_a51_keystream_core.sv
// tb_a51_keystream_core: randomized A5/1 sessions checked against an integer-arithmetic reference model
module tb_a51_keystream_core;
  logic clk = 1'b0, clr = 1'b1, enable = 1'b0;
  logic stage_one = 1'b0, stage_two = 1'b0, stage_three = 1'b0, output_stage = 1'b0, done = 1'b0;
  logic key_bit = 1'b0, frame_bit = 1'b0, data_bit = 1'b0;
  logic ks_bit, cipher_bit, ks_valid, seq_err;

  a51_keystream_core dut (
    .clk(clk), .clr(clr), .enable(enable),
    .stage_one(stage_one), .stage_two(stage_two), .stage_three(stage_three),
    .output_stage(output_stage), .done(done),
    .key_bit(key_bit), .frame_bit(frame_bit), .data_bit(data_bit),
    .ks_bit(ks_bit), .cipher_bit(cipher_bit), .ks_valid(ks_valid), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; bit ks; bit cb;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, pulses = 0;
  bit ks_m [228];
  bit cap_ks [228];
  bit cap_cb [228];
  bit dat [230];
  bit dat_orig [228];
  bit ct [228];
  logic [7:0] gsm [15];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", n, a, x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned step(int unsigned v, int n, int unsigned taps, bit b);
    return ((v << 1) | (($countones(v & taps) & 1) ^ b)) & ((32'd1 << n) - 1);
  endfunction

  // Reference keystream: load key then frame, 100 discarded majority steps, 228 output steps
  function automatic void model(logic [63:0] key, logic [21:0] frame);
    int unsigned r [3];
    int unsigned taps [3];
    int len [3];
    int cbit [3];
    int votes;
    bit b;
    r = '{0, 0, 0};
    taps = '{32'h72000, 32'h300000, 32'h700080};
    len = '{19, 22, 23};
    cbit = '{8, 10, 10};
    for (int i = 0; i < 86; i++) begin
      b = i < 64 ? key[i] : frame[i - 64];
      for (int k = 0; k < 3; k++) r[k] = step(r[k], len[k], taps[k], b);
    end
    for (int i = 0; i < 328; i++) begin
      votes = 0;
      for (int k = 0; k < 3; k++) votes += (r[k] >> cbit[k]) & 1;
      for (int k = 0; k < 3; k++)
        if (((r[k] >> cbit[k]) & 1) == (votes >= 2)) r[k] = step(r[k], len[k], taps[k], 1'b0);
      if (i >= 100) ks_m[i - 100] = ((r[0] >> 18) ^ (r[1] >> 21) ^ (r[2] >> 22)) & 1;
    end
  endfunction

  always @(negedge clk) begin
    if (ks_valid) begin
      exp_t e;
      pulses++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_pulse: ks_valid=1 required 0");
      end else begin
        e = q.pop_front();
        chk($sformatf("ks_bit[%0d]", e.idx), ks_bit, e.ks);
        chk($sformatf("cipher_bit[%0d]", e.idx), cipher_bit, e.cb);
        cap_ks[e.idx] = ks_bit;
        cap_cb[e.idx] = cipher_bit;
      end
    end
  end

  task automatic fill_rand();
    for (int i = 0; i < 230; i++) dat[i] = 1'($urandom);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  task automatic run_seq(input logic [63:0] key, input logic [21:0] frame, input int out_len,
                         input int gap_at, input int gap_len, input int abort_at, input bit exp_err);
    model(key, frame);
    stage_one = 1'b1;
    for (int i = 0; i < 64; i++) begin
      key_bit = key[i];
      tick();
    end
    stage_one = 1'b0;
    key_bit = 1'b0;
    stage_two = 1'b1;
    for (int i = 0; i < 22; i++) begin
      frame_bit = frame[i];
      tick();
    end
    stage_two = 1'b0;
    frame_bit = 1'b0;
    stage_three = 1'b1;
    repeat (100) tick();
    stage_three = 1'b0;
    output_stage = 1'b1;
    for (int i = 0; i < out_len; i++) begin
      if (i == abort_at) begin
        clr = 1'b1;
        #1;
        chk("abort_ks_valid", ks_valid, 0);
        q.delete();
        tick();
        output_stage = 1'b0;
        clr = 1'b0;
        tick();
        chk("abort_seq_err", seq_err, 0);
        return;
      end
      if (i == gap_at) begin
        enable = 1'b0;
        repeat (gap_len) tick();
        enable = 1'b1;
      end
      data_bit = dat[i];
      if (i < 228) q.push_back('{i, ks_m[i], ks_m[i] ^ dat[i]});
      tick();
    end
    output_stage = 1'b0;
    done = 1'b1;
    repeat (3) tick();
    done = 1'b0;
    repeat (2) tick();
    chk("drain", q.size(), 0);
    chk("seq_err", seq_err, exp_err);
    chk("hold_ks_bit", ks_bit, ks_m[227]);
    chk("idle_ks_valid", ks_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] key;
    logic [21:0] fr;
    int errs;
    logic [7:0] byte_m, byte_d;
    gsm = '{8'h53, 8'h4E, 8'hAA, 8'h58, 8'h2F, 8'hE8, 8'h15, 8'h1A,
            8'hB6, 8'hE1, 8'h85, 8'h5A, 8'h72, 8'h8C, 8'h00};
    // T1 reset and idle
    #1;
    repeat (5) tick();
    chk("reset_outputs", {ks_bit, cipher_bit, ks_valid, seq_err}, 0);
    clr = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_bit = 1'($urandom);
      tick();
      chk("idle_outputs", {ks_bit, cipher_bit, ks_valid, seq_err}, 0);
    end
    // T2 all-zero key and frame
    fill_rand();
    pulses = 0;
    run_seq(64'd0, 22'd0, 228, -1, 0, -1, 1'b0);
    chk("t2_pulses", pulses, 228);
    errs = 0;
    for (int i = 0; i < 228; i++) errs += ks_m[i];
    chk("t2_model_zero", errs, 0);
    // T3 published GSM vector
    fill_rand();
    for (int i = 0; i < 228; i++) dat_orig[i] = dat[i];
    run_seq(64'hEFCDAB8967452312, 22'h134, 228, -1, 0, -1, 1'b0);
    for (int b = 0; b < 15; b++) begin
      byte_m = 8'h00;
      byte_d = 8'h00;
      for (int j = 0; j < 8; j++)
        if (b * 8 + j < 114) begin
          byte_m[7 - j] = ks_m[b * 8 + j];
          byte_d[7 - j] = cap_ks[b * 8 + j];
        end
      chk($sformatf("gsm_model_byte%0d", b), byte_m, gsm[b]);
      chk($sformatf("gsm_dut_byte%0d", b), byte_d, gsm[b]);
    end
    for (int i = 0; i < 228; i++) ct[i] = cap_cb[i];
    // T4 decrypt the captured ciphertext with a second identical run
    for (int i = 0; i < 228; i++) dat[i] = ct[i];
    run_seq(64'hEFCDAB8967452312, 22'h134, 228, -1, 0, -1, 1'b0);
    errs = 0;
    for (int i = 0; i < 228; i++) errs += (cap_cb[i] != dat_orig[i]);
    chk("t4_symmetry", errs, 0);
    // T6a enable gap at output bit 50
    fill_rand();
    key = {$urandom, $urandom};
    fr = 22'($urandom);
    pulses = 0;
    run_seq(key, fr, 228, 50, 10, -1, 1'b0);
    chk("t6a_pulses", pulses, 228);
    // randomized sessions with random gaps
    for (int n = 0; n < 2; n++) begin
      fill_rand();
      key = {$urandom, $urandom};
      fr = 22'($urandom);
      run_seq(key, fr, 228, int'($urandom_range(0, 227)), int'($urandom_range(1, 5)), -1, 1'b0);
    end
    // T6b clr mid-output, then a full reload
    fill_rand();
    key = {$urandom, $urandom};
    fr = 22'($urandom);
    run_seq(key, fr, 228, -1, 0, 100, 1'b0);
    repeat (3) begin
      tick();
      chk("post_abort_ks_valid", ks_valid, 0);
    end
    fill_rand();
    run_seq(key, fr, 228, -1, 0, -1, 1'b0);
    // KEY re-entry straight out of a short MIX restarts from zeroed registers
    stage_one = 1'b1;
    repeat (64) begin
      key_bit = 1'($urandom);
      tick();
    end
    stage_one = 1'b0;
    stage_two = 1'b1;
    repeat (22) tick();
    stage_two = 1'b0;
    stage_three = 1'b1;
    repeat (30) tick();
    stage_three = 1'b0;
    fill_rand();
    key = {$urandom, $urandom};
    fr = 22'($urandom);
    run_seq(key, fr, 228, -1, 0, -1, 1'b1);
    pulse_clr();
    // output_stage held past the last bit: extra cycles freeze and flag a length error
    fill_rand();
    pulses = 0;
    run_seq(key, fr, 230, -1, 0, -1, 1'b1);
    chk("over_pulses", pulses, 228);
    pulse_clr();
    chk("over_clr_seq_err", seq_err, 0);
    // T5 short key phase
    stage_one = 1'b1;
    repeat (63) tick();
    chk("t5_before", seq_err, 0);
    stage_one = 1'b0;
    stage_two = 1'b1;
    tick();
    chk("t5_after", seq_err, 1);
    stage_two = 1'b0;
    repeat (10) tick();
    chk("t5_sticky", seq_err, 1);
    pulse_clr();
    chk("t5_clr", seq_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
